threat_engagement_controller: RTL and testbench

- Fire-control stage directly downstream of the radar tracking/assessment unit. It also drives that unit's scan request input.
- Issues periodic scan_for_target pulses and watches the radar state, threat_detected and distance_to_target.
- Requires CONFIRM_COUNT consecutive threatening assessments before engaging.
- Manages a finite missile magazine with fire pulse, cooldown and reload.

---
 rtl/threat_engagement_controller_pkg.sv | 27 ++
 rtl/threat_engagement_controller_cycle_timer.sv | 29 ++
 rtl/threat_engagement_controller.sv | 168 ++++++++++++++++
 tb/tb_threat_engagement_controller.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/threat_engagement_controller_pkg.sv
// Shared encodings and default constants for the threat engagement controller
// and its neighbouring radar tracking/assessment unit.
package threat_engagement_controller_pkg;

  typedef enum logic [2:0] {
    ENG_SURVEIL  = 3'd0,
    ENG_ARM      = 3'd1,
    ENG_FIRE     = 3'd2,
    ENG_COOLDOWN = 3'd3,
    ENG_EMPTY    = 3'd4
  } engage_state_e;

  typedef enum logic [1:0] {
    ARTAU_IDLE   = 2'd0,
    ARTAU_EMIT   = 2'd1,
    ARTAU_LISTEN = 2'd2,
    ARTAU_ASSESS = 2'd3
  } artau_state_e;

  localparam int DEF_SCAN_PERIOD     = 200;
  localparam int DEF_CONFIRM_COUNT   = 2;
  localparam int DEF_MIN_ENGAGE_DIST = 500;
  localparam int DEF_FIRE_PULSE      = 6;
  localparam int DEF_COOLDOWN        = 40;
  localparam int DEF_MAGAZINE        = 4;

endpackage

// File: rtl/threat_engagement_controller_cycle_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module cycle_timer #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // load wins over counting; the counter parks at zero rather than wrapping
  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= RESET_VALUE;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/threat_engagement_controller.sv
// Fire-control stage: periodic radar scan requests, threat confirmation,
// and missile launch with cooldown and a finite, reloadable magazine.
module threat_engagement_controller
  import threat_engagement_controller_pkg::*;
#(
  parameter int SCAN_PERIOD     = DEF_SCAN_PERIOD,
  parameter int CONFIRM_COUNT   = DEF_CONFIRM_COUNT,
  parameter int MIN_ENGAGE_DIST = DEF_MIN_ENGAGE_DIST,
  parameter int FIRE_PULSE      = DEF_FIRE_PULSE,
  parameter int COOLDOWN        = DEF_COOLDOWN,
  parameter int MAGAZINE        = DEF_MAGAZINE
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  ARTAU_state,
  input  logic        threat_detected,
  input  logic [31:0] distance_to_target,
  input  logic        reload,
  output logic        scan_for_target,
  output logic        fire_command,
  output logic        abort_close,
  output logic [7:0]  missiles_left,
  output logic [31:0] engaged_distance,
  output logic [2:0]  engage_state
);

  localparam logic [3:0]  CONFIRM_TARGET = 4'(CONFIRM_COUNT);
  localparam logic [7:0]  MAG_FULL       = 8'(MAGAZINE);
  localparam logic [31:0] MIN_DIST       = 32'(MIN_ENGAGE_DIST);
  localparam logic [31:0] SCAN_RELOAD    = 32'(SCAN_PERIOD - 1);

  engage_state_e state_q, state_d;
  logic [1:0]    prev_artau;
  logic [3:0]    confirm_cnt;
  logic [3:0]    confirm_next;
  logic          assess_evt, no_echo_evt, threat_assess, confirm_hit, engage_ok;
  logic          counting, scan_fire, scan_load, scan_done;
  logic          phase_load, phase_en, phase_done;
  logic [31:0]   phase_value;

  assign assess_evt    = (ARTAU_state == ARTAU_ASSESS) && (prev_artau != ARTAU_ASSESS);
  assign no_echo_evt   = (prev_artau == ARTAU_LISTEN) && (ARTAU_state == ARTAU_IDLE);
  assign threat_assess = assess_evt && threat_detected;
  assign confirm_next  = confirm_cnt + 4'd1;
  assign confirm_hit   = threat_assess && (confirm_next == CONFIRM_TARGET);
  assign engage_ok     = (distance_to_target >= MIN_DIST);
  assign counting      = (state_q == ENG_SURVEIL) || (state_q == ENG_EMPTY);

  // Scan timer free-runs only while surveilling; elsewhere it is parked at a fresh period.
  assign scan_fire = counting && scan_done;
  assign scan_load = !counting || scan_done;

  cycle_timer #(
    .WIDTH       (32),
    .RESET_VALUE (SCAN_RELOAD)
  ) u_scan_timer (
    .CLK        (CLK),
    .RST        (RST),
    .load       (scan_load),
    .load_value (SCAN_RELOAD),
    .enable     (counting),
    .done       (scan_done)
  );

  assign phase_en = (state_q == ENG_FIRE) || (state_q == ENG_COOLDOWN);

  cycle_timer #(
    .WIDTH       (32),
    .RESET_VALUE ('0)
  ) u_phase_timer (
    .CLK        (CLK),
    .RST        (RST),
    .load       (phase_load),
    .load_value (phase_value),
    .enable     (phase_en),
    .done       (phase_done)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ENG_SURVEIL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_load   = 1'b0;
    phase_value  = '0;
    fire_command = (state_q == ENG_FIRE);
    engage_state = state_q;
    case (state_q)
      ENG_SURVEIL: begin
        if (confirm_hit && engage_ok) begin
          state_d = ENG_ARM;
        end
      end
      ENG_ARM: begin
        if (missiles_left == 8'd0) begin
          state_d = ENG_EMPTY;
        end else begin
          state_d     = ENG_FIRE;
          phase_load  = 1'b1;
          phase_value = 32'(FIRE_PULSE - 1);
        end
      end
      ENG_FIRE: begin
        if (phase_done) begin
          state_d     = ENG_COOLDOWN;
          phase_load  = 1'b1;
          phase_value = 32'(COOLDOWN - 1);
        end
      end
      ENG_COOLDOWN: begin
        if (phase_done) begin
          state_d = (missiles_left == 8'd0) ? ENG_EMPTY : ENG_SURVEIL;
        end
      end
      ENG_EMPTY: begin
        if (reload) begin
          state_d = ENG_SURVEIL;
        end
      end
      default: state_d = ENG_SURVEIL;
    endcase
  end

  // Confirmation, magazine and latched range; counting is frozen at zero while engaging.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_artau       <= ARTAU_IDLE;
      confirm_cnt      <= '0;
      missiles_left    <= MAG_FULL;
      engaged_distance <= '0;
      scan_for_target  <= 1'b0;
      abort_close      <= 1'b0;
    end else begin
      prev_artau      <= ARTAU_state;
      scan_for_target <= scan_fire;
      abort_close     <= 1'b0;
      if (counting) begin
        if (threat_assess) begin
          if (confirm_hit) begin
            confirm_cnt      <= '0;
            engaged_distance <= distance_to_target;
            if ((state_q == ENG_SURVEIL) && !engage_ok) begin
              abort_close <= 1'b1;
            end
          end else begin
            confirm_cnt <= confirm_next;
          end
        end else if (assess_evt || no_echo_evt) begin
          confirm_cnt <= '0;
        end
        if (reload) begin
          missiles_left <= MAG_FULL;
        end
      end else begin
        confirm_cnt <= '0;
        if ((state_q == ENG_ARM) && (missiles_left != 8'd0)) begin
          missiles_left <= missiles_left - 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_threat_engagement_controller.sv
// Randomized and directed bench for threat_engagement_controller, checked
// every cycle against a behavioural model of the engagement rules.
module tb_threat_engagement_controller;
  import threat_engagement_controller_pkg::*;

  localparam int SCAN   = 200;
  localparam int CONF   = 2;
  localparam int MIN_D  = 500;
  localparam int FIRE_W = 6;
  localparam int COOL   = 40;
  localparam int MAG    = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  ARTAU_state;
  logic        threat_detected;
  logic [31:0] distance_to_target;
  logic        reload;
  logic        scan_for_target, fire_command, abort_close;
  logic [7:0]  missiles_left;
  logic [31:0] engaged_distance;
  logic [2:0]  engage_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int first_scan = -1;
  int scan_seen = 0;
  int fire_seen = 0;
  int abort_seen = 0;

  // reference model: mode 0..4 follows the published state numbering
  int          m_mode, m_age, m_conf, m_prev, m_miss, m_left, m_scan, m_abort;
  logic [31:0] m_dist;

  threat_engagement_controller #(
    .SCAN_PERIOD     (SCAN),
    .CONFIRM_COUNT   (CONF),
    .MIN_ENGAGE_DIST (MIN_D),
    .FIRE_PULSE      (FIRE_W),
    .COOLDOWN        (COOL),
    .MAGAZINE        (MAG)
  ) dut (
    .CLK                (CLK),
    .RST                (RST),
    .ARTAU_state        (ARTAU_state),
    .threat_detected    (threat_detected),
    .distance_to_target (distance_to_target),
    .reload             (reload),
    .scan_for_target    (scan_for_target),
    .fire_command       (fire_command),
    .abort_close        (abort_close),
    .missiles_left      (missiles_left),
    .engaged_distance   (engaged_distance),
    .engage_state       (engage_state)
  );

  always #5 CLK = ~CLK;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelStep();
    bit assess, noecho;
    int nxt;
    if (RST) begin
      m_mode = 0; m_age = 0; m_conf = 0; m_prev = 0; m_miss = MAG;
      m_left = 0; m_scan = 0; m_abort = 0; m_dist = '0;
    end else begin
      assess = (ARTAU_state == 2'd3) && (m_prev != 3);
      noecho = (m_prev == 2) && (ARTAU_state == 2'd0);
      m_prev = int'(ARTAU_state);
      m_scan = 0;
      m_abort = 0;
      if (m_mode == 0 || m_mode == 4) begin
        if (m_age == SCAN - 1) begin
          m_scan = 1;
          m_age = 0;
        end else begin
          m_age++;
        end
      end else begin
        m_age = 0;
      end
      nxt = m_mode;
      if (m_mode == 0 || m_mode == 4) begin
        if (assess && threat_detected) begin
          m_conf++;
          if (m_conf == CONF) begin
            m_conf = 0;
            m_dist = distance_to_target;
            if (m_mode == 0) begin
              if (distance_to_target >= 32'(MIN_D)) nxt = 1;
              else m_abort = 1;
            end
          end
        end else if (assess || noecho) begin
          m_conf = 0;
        end
        if (reload) begin
          m_miss = MAG;
          if (m_mode == 4) nxt = 0;
        end
      end else if (m_mode == 1) begin
        m_conf = 0;
        if (m_miss == 0) nxt = 4;
        else begin
          m_miss--;
          m_left = FIRE_W;
          nxt = 2;
        end
      end else if (m_mode == 2) begin
        m_conf = 0;
        m_left--;
        if (m_left == 0) begin
          m_left = COOL;
          nxt = 3;
        end
      end else begin
        m_conf = 0;
        m_left--;
        if (m_left == 0) nxt = (m_miss == 0) ? 4 : 0;
      end
      m_mode = nxt;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] st, input logic thr, input logic [31:0] d,
                               input logic rel, input logic rst);
    ARTAU_state        = st;
    threat_detected    = thr;
    distance_to_target = d;
    reload             = rel;
    RST                = rst;
    @(posedge CLK);
    modelStep();
    #1;
    if (rst) begin
      cyc = 0;
      first_scan = -1;
    end else begin
      cyc++;
    end
    if (scan_for_target === 1'b1) begin
      scan_seen++;
      if (first_scan < 0) first_scan = cyc;
    end
    if (fire_command === 1'b1) fire_seen++;
    if (abort_close === 1'b1) abort_seen++;
    checkOutput("scan", 32'(scan_for_target), 32'(m_scan));
    checkOutput("fire", 32'(fire_command), (m_mode == 2) ? 32'd1 : 32'd0);
    checkOutput("abort", 32'(abort_close), 32'(m_abort));
    checkOutput("missiles", 32'(missiles_left), 32'(m_miss));
    checkOutput("edist", engaged_distance, m_dist);
    checkOutput("state", 32'(engage_state), 32'(m_mode));
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(ARTAU_IDLE, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic sweep(input logic thr, input logic [31:0] d);
    repeat (2) applyStimulus(ARTAU_EMIT, 1'b0, 32'd0, 1'b0, 1'b0);
    repeat (3) applyStimulus(ARTAU_LISTEN, 1'b0, 32'd0, 1'b0, 1'b0);
    repeat (2) applyStimulus(ARTAU_ASSESS, thr, d, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic noEcho();
    repeat (2) applyStimulus(ARTAU_EMIT, 1'b0, 32'd0, 1'b0, 1'b0);
    repeat (3) applyStimulus(ARTAU_LISTEN, 1'b0, 32'd0, 1'b0, 1'b0);
    idle(1);
  endtask

  function automatic logic [31:0] pickDist();
    case ($urandom_range(0, 4))
      0:       return 32'd499;
      1:       return 32'd500;
      2:       return 32'($urandom_range(0, 499));
      3:       return 32'($urandom_range(500, 3000));
      default: return $urandom;
    endcase
  endfunction

  task automatic randomCycle(input logic [1:0] st, input int threat_pct);
    logic thr, rel, rst;
    thr = ($urandom_range(0, 99) < threat_pct);
    rel = ($urandom_range(0, 99) < 1);
    rst = ($urandom_range(0, 999) < 2);
    applyStimulus(st, thr, pickDist(), rel, rst);
  endtask

  initial begin
    int waited;
    $display("[TB] start");
    repeat (2) applyStimulus(ARTAU_IDLE, 1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("rst_missiles", 32'(missiles_left), 32'd4);
    checkOutput("rst_state", 32'(engage_state), 32'd0);

    scan_seen = 0;
    idle(600);
    checkOutput("scan_first", 32'(first_scan), 32'd200);
    checkOutput("scan_count", 32'(scan_seen), 32'd3);

    fire_seen = 0;
    sweep(1'b1, 32'd1200);
    sweep(1'b1, 32'd1200);
    idle(60);
    checkOutput("eng_fire_width", 32'(fire_seen), 32'd6);
    checkOutput("eng_missiles", 32'(missiles_left), 32'd3);
    checkOutput("eng_dist", engaged_distance, 32'd1200);

    fire_seen = 0;
    sweep(1'b1, 32'd1200);
    noEcho();
    sweep(1'b1, 32'd1200);
    idle(5);
    checkOutput("noecho_nofire", 32'(fire_seen), 32'd0);
    sweep(1'b1, 32'd1200);
    idle(60);
    checkOutput("noecho_third", 32'(fire_seen), 32'd6);
    checkOutput("noecho_missiles", 32'(missiles_left), 32'd2);

    abort_seen = 0; fire_seen = 0;
    sweep(1'b1, 32'd300);
    sweep(1'b1, 32'd300);
    idle(5);
    checkOutput("close_abort", 32'(abort_seen), 32'd1);
    checkOutput("close_nofire", 32'(fire_seen), 32'd0);
    checkOutput("close_state", 32'(engage_state), 32'd0);
    sweep(1'b1, 32'd499);
    sweep(1'b1, 32'd499);
    idle(5);
    checkOutput("abort_499", 32'(abort_seen), 32'd2);

    sweep(1'b1, 32'd500);
    sweep(1'b1, 32'd500);
    idle(60);
    sweep(1'b1, 32'hFFFF_FFFF);
    sweep(1'b1, 32'hFFFF_FFFF);
    idle(60);
    checkOutput("empty_state", 32'(engage_state), 32'd4);
    checkOutput("empty_missiles", 32'(missiles_left), 32'd0);
    fire_seen = 0;
    sweep(1'b1, 32'd800);
    sweep(1'b1, 32'd800);
    idle(5);
    checkOutput("empty_nofire", 32'(fire_seen), 32'd0);
    checkOutput("empty_latch", engaged_distance, 32'd800);
    applyStimulus(ARTAU_IDLE, 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("reload_missiles", 32'(missiles_left), 32'd4);
    checkOutput("reload_state", 32'(engage_state), 32'd0);

    sweep(1'b1, 32'd1000);
    repeat (2) applyStimulus(ARTAU_EMIT, 1'b0, 32'd0, 1'b0, 1'b0);
    repeat (3) applyStimulus(ARTAU_LISTEN, 1'b0, 32'd0, 1'b0, 1'b0);
    applyStimulus(ARTAU_ASSESS, 1'b1, 32'd1000, 1'b0, 1'b0);
    waited = 0;
    while ((fire_command !== 1'b1) && (waited < 10)) begin
      idle(1);
      waited++;
    end
    checkOutput("fire_start", 32'(fire_command), 32'd1);
    idle(2);
    applyStimulus(ARTAU_IDLE, 1'b0, 32'd0, 1'b0, 1'b1);
    checkOutput("rstfire_fire", 32'(fire_command), 32'd0);
    checkOutput("rstfire_missiles", 32'(missiles_left), 32'd4);
    checkOutput("rstfire_state", 32'(engage_state), 32'd0);
    idle(200);
    checkOutput("rstfire_scan", 32'(first_scan), 32'd200);

    for (int s = 0; s < 250; s++) begin
      repeat ($urandom_range(0, 25)) randomCycle(ARTAU_IDLE, 50);
      repeat ($urandom_range(1, 3)) randomCycle(ARTAU_EMIT, 50);
      repeat ($urandom_range(1, 4)) randomCycle(ARTAU_LISTEN, 50);
      if ($urandom_range(0, 99) < 75) begin
        repeat ($urandom_range(1, 3)) randomCycle(ARTAU_ASSESS, 70);
      end
      randomCycle(ARTAU_IDLE, 50);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
